// File: rtl/mul_div_unit.sv
// ----------------------------------------------------------------------------
// mul_div_unit
//
// Iterative 32x32 multiply / divide unit, one result bit per clock.
//   Multiply: shift-add, full 64-bit product returned on {Hi, Lo}.
//   Divide  : restoring shift-subtract, quotient on Lo, remainder on Hi.
//
// Ports
//   Clk     in   single clock, rising edge
//   Reset   in   synchronous, active-high
//   Start   in   request pulse, accepted only in IDLE or DONE
//   MDCon   in   [1:0] 00 multu, 01 divu, 10 mult signed, 11 div signed
//   DataA   in   [31:0] multiplicand / dividend (captured with Start)
//   DataB   in   [31:0] multiplier / divisor (captured with Start)
//   Busy    out  high in PREP, CALC and FIX
//   Done    out  one-cycle completion pulse (DONE state)
//   Hi      out  [31:0] product[63:32] or remainder
//   Lo      out  [31:0] product[31:0] or quotient
//   Flag    out  [Flag_Width-1:0] {Underflow, Overflow, DivByZero}
//
// Build option
//   MDU_SIGNED_EN  defined   : MDCon[1] selects signed operation.
//                  undefined : every operation is unsigned, MDCon[1] has no
//                              effect, Overflow never sets. Latency unchanged.
// ----------------------------------------------------------------------------
// state | meaning
// IDLE  | waiting for Start
// PREP  | operands captured; take magnitudes, record result signs
// CALC  | 32 single-bit iterations
// FIX   | apply result signs, load Hi/Lo/Flag
// DONE  | Done pulse; Start here begins the next operation directly
// ----------------------------------------------------------------------------
module mul_div_unit #(
    parameter int Flag_Width = 3
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [1:0]            MDCon,
    input  logic [31:0]           DataA,
    input  logic [31:0]           DataB,
    output logic                  Busy,
    output logic                  Done,
    output logic [31:0]           Hi,
    output logic [31:0]           Lo,
    output logic [Flag_Width-1:0] Flag
);

`ifdef MDU_SIGNED_EN
    localparam logic SIGNED_EN = 1'b1;
`else
    localparam logic SIGNED_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Working registers: r_hi/r_lo hold the partial product or the
    // remainder/quotient pair; r_lo starts out holding operand A.
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_opb;
    logic [1:0]  r_mdcon;
    logic [5:0]  r_cnt;
    logic        r_neg_q;     // negate product / quotient in FIX
    logic        r_neg_r;     // negate remainder in FIX
    logic        r_ovf;

    logic [31:0]           r_hi_out;
    logic [31:0]           r_lo_out;
    logic [Flag_Width-1:0] r_flag;

    logic        w_is_div;
    logic        w_signed;
    logic        w_sign_a;
    logic        w_sign_b;
    logic        w_div_zero;
    logic        w_accept;
    logic [32:0] w_mul_sum;
    logic [32:0] w_rem_sh;
    logic        w_sub_ok;
    logic [31:0] w_rem_new;
    logic [63:0] w_prod_neg;
    logic [31:0] w_fix_hi;
    logic [31:0] w_fix_lo;

    assign w_is_div   = r_mdcon[0];
    assign w_signed   = r_mdcon[1] & SIGNED_EN;
    assign w_sign_a   = w_signed & r_lo[31];
    assign w_sign_b   = w_signed & r_opb[31];
    assign w_div_zero = w_is_div & (r_opb == 32'd0);
    assign w_accept   = Start & ((r_state == IDLE) | (r_state == DONE));

    // Multiply step: conditionally add B into the upper half, then the
    // 65-bit {carry, hi, lo} shifts right by one.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : 33'd0);

    // Divide step: shift the next dividend bit into the remainder and keep
    // the difference only if it did not go negative. When the subtraction
    // is kept the true difference is below the divisor, so 32 bits suffice.
    assign w_rem_sh  = {r_hi, r_lo[31]};
    assign w_sub_ok  = (w_rem_sh >= {1'b0, r_opb});
    assign w_rem_new = w_sub_ok ? (w_rem_sh[31:0] - r_opb) : w_rem_sh[31:0];

    assign w_prod_neg = 64'd0 - {r_hi, r_lo};

    always_comb begin
        w_fix_hi = r_hi;
        w_fix_lo = r_lo;
        if (w_is_div) begin
            if (r_neg_q) w_fix_lo = 32'd0 - r_lo;
            if (r_neg_r) w_fix_hi = 32'd0 - r_hi;
        end else if (r_neg_q) begin
            w_fix_hi = w_prod_neg[63:32];
            w_fix_lo = w_prod_neg[31:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = PREP;
            PREP:    w_state_next = w_div_zero ? DONE : CALC;
            CALC:    if (r_cnt == 6'd1) w_state_next = FIX;
            FIX:     w_state_next = DONE;
            DONE:    w_state_next = w_accept ? PREP : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_opb    <= 32'd0;
            r_mdcon  <= 2'd0;
            r_cnt    <= 6'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_ovf    <= 1'b0;
            r_hi_out <= 32'd0;
            r_lo_out <= 32'd0;
            r_flag   <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_lo    <= DataA;
                        r_opb   <= DataB;
                        r_mdcon <= MDCon;
                    end
                end
                PREP: begin
                    if (w_div_zero) begin
                        // r_lo still holds the untouched dividend here.
                        r_hi_out <= r_lo;
                        r_lo_out <= 32'hFFFF_FFFF;
                        r_flag   <= Flag_Width'(3'b001);
                    end else begin
                        r_hi    <= 32'd0;
                        r_lo    <= w_sign_a ? (32'd0 - r_lo)  : r_lo;
                        r_opb   <= w_sign_b ? (32'd0 - r_opb) : r_opb;
                        r_cnt   <= 6'd32;
                        r_neg_q <= w_sign_a ^ w_sign_b;
                        r_neg_r <= w_sign_a;
                        // The magnitude path already yields 0x80000000 for
                        // this case; only the flag needs raising.
                        r_ovf   <= w_is_div & w_signed &
                                   (r_lo == 32'h8000_0000) &
                                   (r_opb == 32'hFFFF_FFFF);
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt - 6'd1;
                    if (w_is_div) begin
                        r_hi <= w_rem_new;
                        r_lo <= {r_lo[30:0], w_sub_ok};
                    end else begin
                        r_hi <= w_mul_sum[32:1];
                        r_lo <= {w_mul_sum[0], r_lo[31:1]};
                    end
                end
                FIX: begin
                    r_hi_out <= w_fix_hi;
                    r_lo_out <= w_fix_lo;
                    r_flag   <= Flag_Width'({1'b0, r_ovf, 1'b0});
                end
                default: ;
            endcase
        end
    end

    assign Busy = (r_state == PREP) | (r_state == CALC) | (r_state == FIX);
    assign Done = (r_state == DONE);
    assign Hi   = r_hi_out;
    assign Lo   = r_lo_out;
    assign Flag = r_flag;

endmodule

// File: tb/tb_mul_div_unit.sv
// ----------------------------------------------------------------------------
// tb_mul_div_unit
//
// Directed test of mul_div_unit. A transaction-level model predicts Busy,
// Done and the held Hi/Lo/Flag from plain 64-bit arithmetic; a compare
// process checks the DUT against it on every falling edge. Each directed
// operation also checks its Done edge and result against literal values.
// Honors MDU_SIGNED_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_mul_div_unit;

`ifdef MDU_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [1:0]  MDCon;
    logic [31:0] DataA;
    logic [31:0] DataB;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic [2:0]  Flag;

    int tests = 0;
    int fails = 0;

    mul_div_unit #(.Flag_Width(3)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .MDCon (MDCon),
        .DataA (DataA),
        .DataB (DataB),
        .Busy  (Busy),
        .Done  (Done),
        .Hi    (Hi),
        .Lo    (Lo),
        .Flag  (Flag)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Result rules: product sign = sign(A)^sign(B), quotient truncates toward
    // zero, remainder follows the dividend (SystemVerilog / and % on longint
    // already behave this way). fin = edges after acceptance until DONE.
    task automatic compute(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo,
                           output logic [2:0] fl, output int fin);
        bit          sg;
        longint      sa;
        longint      sb;
        longint      p;
        logic [63:0] up;
        sg  = SGN && op[1];
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        fl  = 3'b000;
        fin = 34;
        if (!op[0]) begin
            if (sg) begin
                p = sa * sb;
                {hi, lo} = p;
            end else begin
                up = {32'd0, a} * {32'd0, b};
                {hi, lo} = up;
            end
        end else if (b == 32'd0) begin
            hi  = a;
            lo  = 32'hFFFF_FFFF;
            fl  = 3'b001;
            fin = 1;
        end else if (sg) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                lo = 32'h8000_0000;
                hi = 32'd0;
                fl = 3'b010;
            end else begin
                lo = 32'(sa / sb);
                hi = 32'(sa % sb);
            end
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endtask

    bit          m_active = 1'b0;
    int          m_k = 0;
    int          m_fin = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [2:0]  m_flag = 3'd0;
    logic [31:0] p_hi = 32'd0;
    logic [31:0] p_lo = 32'd0;
    logic [2:0]  p_flag = 3'd0;

    always @(posedge Clk) begin
        if (Reset) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_hi     = 32'd0;
            m_lo     = 32'd0;
            m_flag   = 3'd0;
        end else begin
            m_done = 1'b0;
            if (m_active) begin
                m_k++;
                if (m_k == m_fin) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                    m_hi     = p_hi;
                    m_lo     = p_lo;
                    m_flag   = p_flag;
                end
            end else if (Start) begin
                m_active = 1'b1;
                m_k      = 0;
                compute(MDCon, DataA, DataB, p_hi, p_lo, p_flag, m_fin);
            end
        end
    end

    initial begin
        @(posedge Clk);
        forever begin
            @(negedge Clk);
            check("model_busy", Busy, m_active);
            check("model_done", Done, m_done);
            check("model_hi",   Hi,   m_hi);
            check("model_lo",   Lo,   m_lo);
            check("model_flag", Flag, m_flag);
        end
    end

    // ---------------- directed stimulus ----------------
    // Called #1 after an edge; the next edge is edge 0. Inputs are scrambled
    // while busy. With poke, a Start is presented while busy (must be ignored).
    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input logic [2:0] efl, input int eedge, input bit poke);
        int n;
        MDCon = op;
        DataA = a;
        DataB = b;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        MDCon = ~op;
        DataA = ~a;
        DataB = ~b;
        check({name, "_accept_busy"}, Busy, 1'b1);
        check({name, "_accept_done"}, Done, 1'b0);
        n = 0;
        while (Done !== 1'b1 && n < 60) begin
            Start = (poke && n == 5);
            @(posedge Clk);
            #1;
            n++;
        end
        Start = 1'b0;
        check({name, "_done_edge"}, n + 1, eedge);
        check({name, "_hi"},   Hi,   ehi);
        check({name, "_lo"},   Lo,   elo);
        check({name, "_flag"}, Flag, efl);
        check({name, "_busy_at_done"}, Busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        MDCon = 2'b00;
        DataA = 32'd0;
        DataB = 32'd0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset_busy", Busy, 1'b0);
        check("reset_done", Done, 1'b0);
        check("reset_hi",   Hi,   32'd0);
        check("reset_lo",   Lo,   32'd0);
        check("reset_flag", Flag, 3'd0);

        // Reset outranks Start.
        Start = 1'b1;
        @(posedge Clk);
        #1;
        check("reset_prio_busy", Busy, 1'b0);
        Reset = 1'b0;

        // First edge with Reset low accepts; then back-to-back from DONE.
        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 3'b000, 35, 1'b0);
        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 3'b000, 35, 1'b0);

        if (SGN) begin
            run_op("mult_m3_5", 2'b10, 32'hFFFF_FFFD, 32'd5,
                   32'hFFFF_FFFF, 32'hFFFF_FFF1, 3'b000, 35, 1'b0);
            run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2,
                   32'hFFFF_FFFF, 32'hFFFF_FFFD, 3'b000, 35, 1'b0);
        end else begin
            run_op("mult_m3_5", 2'b10, 32'hFFFF_FFFD, 32'd5,
                   32'h0000_0004, 32'hFFFF_FFF1, 3'b000, 35, 1'b0);
            run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2,
                   32'h0000_0001, 32'h7FFF_FFFC, 3'b000, 35, 1'b0);
        end

        repeat (2) @(posedge Clk);
        #1;
        run_op("divu_zero", 2'b01, 32'h1234_5678, 32'd0,
               32'h1234_5678, 32'hFFFF_FFFF, 3'b001, 2, 1'b0);
        repeat (3) @(posedge Clk);
        #1;
        check("hold_hi", Hi, 32'h1234_5678);
        check("hold_flag", Flag, 3'b001);

        if (SGN)
            run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
                   32'd0, 32'h8000_0000, 3'b010, 35, 1'b0);
        else
            run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
                   32'h8000_0000, 32'd0, 3'b000, 35, 1'b0);

        run_op("div_s_zero", 2'b11, 32'h8000_0001, 32'd0,
               32'h8000_0001, 32'hFFFF_FFFF, 3'b001, 2, 1'b0);
        run_op("multu_poke", 2'b00, 32'h0001_0000, 32'h0001_0000,
               32'd1, 32'd0, 3'b000, 35, 1'b1);

        if (SGN) begin
            run_op("mult_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE,
                   32'hFFFF_FFFF, 32'hFFFF_FFF2, 3'b000, 35, 1'b0);
            run_op("div_7_m2", 2'b11, 32'd7, 32'hFFFF_FFFE,
                   32'd1, 32'hFFFF_FFFD, 3'b000, 35, 1'b0);
        end else begin
            run_op("mult_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE,
                   32'd6, 32'hFFFF_FFF2, 3'b000, 35, 1'b0);
            run_op("div_7_m2", 2'b11, 32'd7, 32'hFFFF_FFFE,
                   32'd7, 32'd0, 3'b000, 35, 1'b0);
        end

        // Reset at edge 10 of a multu aborts it.
        MDCon = 2'b00;
        DataA = 32'hFFFF_FFFF;
        DataB = 32'd2;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(posedge Clk);
            #1;
        end
        check("abort_busy_before", Busy, 1'b1);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        check("abort_busy", Busy, 1'b0);
        check("abort_done", Done, 1'b0);
        check("abort_hi",   Hi,   32'd0);
        check("abort_lo",   Lo,   32'd0);
        check("abort_flag", Flag, 3'd0);
        run_op("after_abort", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 3'b000, 35, 1'b0);

        repeat (3) @(posedge Clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter Flag_Width, default 3, which is the width of Flag, ordered {Underflow, Overflow, DivByZero}.
REQ-002 SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port Start, input, 1 bit: request pulse, sampled on rising edge of Clk.
REQ-005 SHALL have port MDCon, input, 2 bits: 00 multu, 01 divu, 10 mult signed, 11 div signed.
REQ-006 SHALL have port DataA, input, 32 bits: multiplicand or dividend, captured with Start.
REQ-007 SHALL have port DataB, input, 32 bits: multiplier or divisor, captured with Start.
REQ-008 SHALL have port Busy, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL have port Done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port Hi, output, 32 bits: product[63:32] or remainder.
REQ-011 SHALL have port Lo, output, 32 bits: product[31:0] or quotient.
REQ-012 SHALL have port Flag, output, Flag_Width bits: status of the last completed operation.

Function
REQ-013 SHALL implement FSM states IDLE, PREP, CALC, FIX, DONE.
REQ-014 SHALL accept Start only in IDLE or DONE, capturing DataA, DataB and MDCon and entering PREP at that edge.
REQ-015 SHALL ignore Start and input changes while Busy=1.
REQ-016 PREP SHALL take absolute values of signed operands, record result signs and enter CALC after 1 cycle.
REQ-017 CALC SHALL run exactly 32 iterations, one bit per cycle: shift-add for multiply, restoring shift-subtract for divide. A 6-bit counter counts the iterations.
REQ-018 FIX SHALL negate results as needed: product sign = sign(A) XOR sign(B); quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-019 In the normal path, the edge that accepts Start SHALL count as edge 0. PREP follows at edge 1, CALC spans edges 2-33, FIX is at edge 34 and DONE is at edge 35.
REQ-020 Done SHALL be 1 only in DONE, for exactly 1 cycle, then the FSM SHALL return to IDLE unless Start is accepted.
REQ-021 Busy SHALL be 1 in PREP, CALC and FIX, and 0 in IDLE and DONE.
REQ-022 Hi, Lo and Flag SHALL update only on entry to DONE and hold until the next DONE or Reset.
REQ-023 On a divide with DataB=0, PREP SHALL go directly to DONE (Done at edge 2) with Hi=DataA, Lo=32'hFFFFFFFF and Flag=3'b001.
REQ-024 On a signed divide of 32'h80000000 by 32'hFFFFFFFF, SHALL produce Lo=32'h80000000, Hi=0 and Flag=3'b010, at normal latency.
REQ-025 Multiply SHALL never set Overflow; the full 64-bit product SHALL be returned.
REQ-026 The Underflow bit SHALL always be 0.
REQ-027 All other completions SHALL produce Flag=3'b000.
REQ-028 Start accepted in DONE SHALL start a new operation back-to-back, with Done low on the following cycle.

Reset
REQ-029 When Reset=1 at a rising edge, SHALL force IDLE, Busy=0, Done=0, Hi=0, Lo=0, Flag=0 and iteration counter=0.
REQ-030 Reset SHALL have priority over Start.
REQ-031 Reset during PREP, CALC or FIX SHALL abort the operation with no Done pulse and no result update.
REQ-032 Start SHALL be accepted on the first edge with Reset=0.

Configuration
REQ-033 When macro MDU_SIGNED_EN is defined, MDCon[1] SHALL select signed operation per REQ-005, REQ-018 and REQ-024.
REQ-034 When MDU_SIGNED_EN is undefined, SHALL ignore MDCon[1], perform all operations unsigned, bypass PREP sign handling and FIX negation (latency unchanged), and keep Flag[1] always 0.

Verification
REQ-035 SHALL cover multu: A=32'hFFFFFFFF, B=32'hFFFFFFFF -> Hi=32'hFFFFFFFE, Lo=32'h00000001, Flag=0, Done at edge 35, Busy high for edges 1-34.
REQ-036 SHALL cover mult signed (MDU_SIGNED_EN defined): A=-3, B=5 -> Hi=32'hFFFFFFFF, Lo=32'hFFFFFFF1.
REQ-037 SHALL cover divu and signed div: 100/7 -> Lo=14, Hi=2; signed -7/2 -> Lo=32'hFFFFFFFD, Hi=32'hFFFFFFFF.
REQ-038 SHALL cover divide by zero: divu A=32'h12345678, B=0 -> Done at edge 2, Hi=32'h12345678, Lo=32'hFFFFFFFF, Flag=3'b001.
REQ-039 SHALL cover signed overflow: div 32'h80000000 / 32'hFFFFFFFF -> Lo=32'h80000000, Hi=0, Flag=3'b010.
REQ-040 SHALL cover Reset at edge 10 of a multu: no Done, Busy=0 and Hi/Lo/Flag=0 next cycle. A Start on the next edge then completes at edge 35 relative to that Start.
